lap_stopwatch_core: RTL
=======================

Name: lap_stopwatch_core

Overview:
Parametrised stopwatch core: mm:ss.cc BCD time base, start/stop/clear control, and a circular lap memory of LAP_DEPTH entries with recall browsing. It sits between the debounced/edge-detected button pulses and the 4-digit FND controller, supplying a 16-bit BCD display word. It replaces single-lap, minute/second-only stopwatch logic with centisecond resolution, multi-lap storage, overflow detection and a display-field select.

Parameters:
TICK_DIV, 1_000_000, clk cycles per centisecond (100 MHz -> 10 ms); must be >= 2
LAP_DEPTH, 8, number of stored laps, power of two, 2..64
CNT_W, $clog2(LAP_DEPTH+1), width of lap_count

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous, active-high reset
start_stop_p  in  1  one-cycle pulse, toggles run/stop, exits recall
lap_p  in  1  one-cycle pulse, captures lap while running
clear_p  in  1  one-cycle pulse, clears time, laps and flags when not running
recall_p  in  1  one-cycle pulse, enters or advances lap recall
disp_sel  in  1  0 = {min10,min1,sec10,sec1}, 1 = {sec10,sec1,cs10,cs1}
time_bcd  out  24  live time {min10,min1,sec10,sec1,cs10,cs1}
disp_value  out  16  field selected by disp_sel, from the live or recalled time
running  out  1  high in RUN
recall_active  out  1  high in RECALL
recall_idx  out  $clog2(LAP_DEPTH)  lap number shown, 0 = oldest stored
lap_count  out  CNT_W  stored laps, saturates at LAP_DEPTH
lap_full  out  1  sticky; set on the first overwrite of the oldest lap
overflow  out  1  sticky; set on wrap from 59:59.99

Behaviour:
- Reset: FSM=IDLE; all outputs 0; prescaler, BCD digits, lap pointers 0. Lap RAM contents are don't-care; they are never read when lap_count=0.
- FSM states: IDLE, RUN, STOP, RECALL. Event priority per cycle: clear_p > start_stop_p > lap_p > recall_p.
- IDLE: start -> RUN; recall with lap_count>0 -> RECALL; lap and clear have no effect.
- RUN: start -> STOP; lap -> store; clear and recall are ignored.
- STOP: start -> RUN; clear -> IDLE; recall with lap_count>0 -> RECALL; lap is ignored.
- RECALL: recall -> advance; start -> STOP (time is unchanged and does not resume); clear -> IDLE.
- Clear: time, prescaler, lap_count, pointers, lap_full and overflow go to 0 on the next edge.
- Prescaler counts 0..TICK_DIV-1 only in RUN and holds its value in STOP/RECALL, so resume is sub-centisecond exact. It emits a tick when it reaches TICK_DIV-1, then wraps to 0.
- Tick increments the BCD time: cs1 0-9, cs10 0-9, sec1 0-9, sec10 0-5, min1 0-9, min10 0-5, with ripple carry in the same cycle.
- 59:59.99 + tick -> 00:00.00 and overflow<=1; the counter keeps running.
- Lap store: at wr_ptr, write the time_bcd value from before the same-edge tick; wr_ptr++ mod LAP_DEPTH; lap_count++ saturating.
- Lap store when lap_count=LAP_DEPTH: the oldest entry is overwritten, rd_base (oldest pointer) advances, and lap_full<=1.
- Lap and start in the same RUN cycle: the lap is stored AND the FSM goes to STOP. This is the only permitted dual action.
- Recall entry sets recall_idx=0 (oldest). Each further recall_p increments it, wrapping from lap_count-1 back to 0.
- Recalled address: (rd_base+recall_idx) mod LAP_DEPTH.
- disp_value: selects from the recalled lap in RECALL, otherwise from time_bcd. It is registered, so it updates 1 cycle after the source changes. Lap RAM reads are synchronous and may use that same cycle.
- time_bcd, running, recall_active, lap_count and the flags are registered and change on the edge after the causing event.
- Asynchronous reset mid-RUN returns everything to reset values immediately; no lap is written.

Decomposition:
- Package lap_stopwatch_pkg: state enum (IDLE, RUN, STOP, RECALL); BCD limit constants CS_MAX=9, SEC10_MAX=5, MIN10_MAX=5; bcd_time_t as a 24-bit packed struct.
- One sub-module, bcd_time_counter: inputs clk, reset_p, clr, tick; outputs 24-bit BCD and wrap pulse. It carries the ripple-carry logic and is reused by a future countdown timer.
- Lap RAM is inferred inline as LAP_DEPTH x 24 bit.

Test Plan:
- TICK_DIV=4: reset, start, run 400 clk -> time_bcd=00:01.00, running=1, disp_sel=1 gives disp_value=16'h0100.
- Start, run 40 clk, stop, wait 100 clk, start, run 40 clk -> time exactly 00:00.20; during STOP, clear -> all zero, state IDLE.
- LAP_DEPTH=4: six laps at times .01..0.06 -> lap_count=4, lap_full=1; recall sequence shows .03, .04, .05, .06, then .03 again.
- Preload 59:59.99, one tick -> 00:00.00, overflow=1; a clear in STOP -> overflow=0.
- Lap_p and start_stop_p in the same RUN cycle as a tick -> lap holds the pre-tick value, FSM=STOP, time holds the post-tick value.
- Recall_p with lap_count=0 -> stays IDLE; clear_p in RUN -> ignored; reset_p mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// rtl/lap_stopwatch_pkg.sv - shared types and BCD limits for the lap stopwatch
package lap_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STOP   = 2'd2,
        RECALL = 2'd3
    } state_t;

    localparam logic [3:0] CS_MAX    = 4'd9;
    localparam logic [3:0] SEC10_MAX = 4'd5;
    localparam logic [3:0] MIN10_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min10;
        logic [3:0] min1;
        logic [3:0] sec10;
        logic [3:0] sec1;
        logic [3:0] cs10;
        logic [3:0] cs1;
    } bcd_time_t;

    // Four-digit display window: minutes/seconds or seconds/centiseconds
    function automatic logic [15:0] sel_field(input bcd_time_t t, input logic sel);
        return sel ? {t.sec10, t.sec1, t.cs10, t.cs1}
                   : {t.min10, t.min1, t.sec10, t.sec1};
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - mm:ss.cc BCD up-counter with same-cycle ripple carry
module bcd_time_counter
    import lap_stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_p,
    input  logic        clr,
    input  logic        tick,
    output logic [23:0] bcd,
    output logic        wrap
);

    bcd_time_t bcd_q;
    bcd_time_t bcd_d;

    always_comb begin
        bcd_d = bcd_q;
        wrap  = 1'b0;
        if (clr) begin
            bcd_d = '0;
        end else if (tick) begin
            if (bcd_q.cs1 != CS_MAX) bcd_d.cs1 = bcd_q.cs1 + 4'd1;
            else begin
                bcd_d.cs1 = 4'd0;
                if (bcd_q.cs10 != CS_MAX) bcd_d.cs10 = bcd_q.cs10 + 4'd1;
                else begin
                    bcd_d.cs10 = 4'd0;
                    if (bcd_q.sec1 != CS_MAX) bcd_d.sec1 = bcd_q.sec1 + 4'd1;
                    else begin
                        bcd_d.sec1 = 4'd0;
                        if (bcd_q.sec10 != SEC10_MAX) bcd_d.sec10 = bcd_q.sec10 + 4'd1;
                        else begin
                            bcd_d.sec10 = 4'd0;
                            if (bcd_q.min1 != CS_MAX) bcd_d.min1 = bcd_q.min1 + 4'd1;
                            else begin
                                bcd_d.min1 = 4'd0;
                                if (bcd_q.min10 != MIN10_MAX) bcd_d.min10 = bcd_q.min10 + 4'd1;
                                else begin
                                    bcd_d.min10 = 4'd0;
                                    wrap        = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) bcd_q <= '0;
        else         bcd_q <= bcd_d;
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/lap_stopwatch_core.sv
// rtl/lap_stopwatch_core.sv - stopwatch control FSM, prescaler and circular lap memory
module lap_stopwatch_core
    import lap_stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 1_000_000,
    parameter int LAP_DEPTH = 8,
    parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset_p,
    input  logic                         start_stop_p,
    input  logic                         lap_p,
    input  logic                         clear_p,
    input  logic                         recall_p,
    input  logic                         disp_sel,
    output logic [23:0]                  time_bcd,
    output logic [15:0]                  disp_value,
    output logic                         running,
    output logic                         recall_active,
    output logic [$clog2(LAP_DEPTH)-1:0] recall_idx,
    output logic [CNT_W-1:0]             lap_count,
    output logic                         lap_full,
    output logic                         overflow
);

    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int PW    = $clog2(TICK_DIV);

    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]   rd_base_q, rd_base_d;
    logic [IDX_W-1:0]   recall_idx_q, recall_idx_d;
    logic [CNT_W-1:0]   lap_count_q, lap_count_d;
    logic               lap_full_q, lap_full_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        disp_q, disp_d;

    logic               tick, wrap, ctr_clr, lap_we;
    logic [IDX_W-1:0]   rd_addr;
    logic [23:0]        lap_mem [LAP_DEPTH];

    bcd_time_counter u_time (
        .clk     (clk),
        .reset_p (reset_p),
        .clr     (ctr_clr),
        .tick    (tick),
        .bcd     (time_bcd),
        .wrap    (wrap)
    );

    assign tick    = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
    assign rd_addr = rd_base_q + recall_idx_q;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_base_d    = rd_base_q;
        recall_idx_d = recall_idx_q;
        lap_count_d  = lap_count_q;
        lap_full_d   = lap_full_q;
        overflow_d   = overflow_q | wrap;
        ctr_clr      = 1'b0;
        lap_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_stop_p) state_d = RUN;
                else if (recall_p && lap_count_q != '0) begin
                    state_d      = RECALL;
                    recall_idx_d = '0;
                end
            end
            RUN: begin
                // lap together with stop is the one case where two events both act
                lap_we = lap_p;
                if (start_stop_p) state_d = STOP;
            end
            STOP: begin
                if (clear_p) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (start_stop_p) state_d = RUN;
                else if (recall_p && lap_count_q != '0) begin
                    state_d      = RECALL;
                    recall_idx_d = '0;
                end
            end
            RECALL: begin
                if (clear_p) begin
                    state_d = IDLE;
                    ctr_clr = 1'b1;
                end else if (start_stop_p) state_d = STOP;
                else if (recall_p) begin
                    if ({1'b0, recall_idx_q} + CNT_W'(1) == lap_count_q) recall_idx_d = '0;
                    else recall_idx_d = recall_idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (ctr_clr) presc_d = '0;
        else if (state_q == RUN) presc_d = tick ? '0 : presc_q + PW'(1);

        if (lap_we) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (lap_count_q == CNT_W'(LAP_DEPTH)) begin
                rd_base_d  = rd_base_q + IDX_W'(1);
                lap_full_d = 1'b1;
            end else begin
                lap_count_d = lap_count_q + CNT_W'(1);
            end
        end

        if (ctr_clr) begin
            wr_ptr_d     = '0;
            rd_base_d    = '0;
            recall_idx_d = '0;
            lap_count_d  = '0;
            lap_full_d   = 1'b0;
            overflow_d   = 1'b0;
        end

        disp_d = sel_field((state_q == RECALL) ? lap_mem[rd_addr] : time_bcd, disp_sel);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            wr_ptr_q     <= '0;
            rd_base_q    <= '0;
            recall_idx_q <= '0;
            lap_count_q  <= '0;
            lap_full_q   <= 1'b0;
            overflow_q   <= 1'b0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_base_q    <= rd_base_d;
            recall_idx_q <= recall_idx_d;
            lap_count_q  <= lap_count_d;
            lap_full_q   <= lap_full_d;
            overflow_q   <= overflow_d;
            disp_q       <= disp_d;
        end
    end

    // Lap contents are never read before being written, so no reset is needed
    always_ff @(posedge clk) begin
        if (lap_we) lap_mem[wr_ptr_q] <= time_bcd;
    end

    assign disp_value    = disp_q;
    assign running       = (state_q == RUN);
    assign recall_active = (state_q == RECALL);
    assign recall_idx    = recall_idx_q;
    assign lap_count     = lap_count_q;
    assign lap_full      = lap_full_q;
    assign overflow      = overflow_q;

endmodule
